// File: rtl/alu_defs_pkg.sv
// alu_defs_pkg: shared definitions for the ALU operand muxes, the ALU
// operation codes and the repeated-addition multiply sequencer.
//   SEL_*      : operand-mux select codes (used by both the A-mux and B-mux)
//   OP_*       : ALU operation codes
//   DATA_W     : datapath width of rrow/rcol/rtotal/rcoltemp
//   mul_state_t: state encoding of alu_mul_seq
package alu_defs_pkg;

  localparam int SEL_WIDTH = 4;
  localparam int OP_WIDTH  = 3;
  localparam int DATA_W    = 18;

  localparam logic [SEL_WIDTH-1:0] SEL_NONE     = 4'b0000;
  localparam logic [SEL_WIDTH-1:0] SEL_RCOL     = 4'b0011;
  localparam logic [SEL_WIDTH-1:0] SEL_RROW     = 4'b0100;
  localparam logic [SEL_WIDTH-1:0] SEL_RTOTAL   = 4'b0111;
  localparam logic [SEL_WIDTH-1:0] SEL_RCOLTEMP = 4'b1010;

  localparam logic [OP_WIDTH-1:0] OP_PASS = 3'b000;
  localparam logic [OP_WIDTH-1:0] OP_ADD  = 3'b001;
  localparam logic [OP_WIDTH-1:0] OP_DEC  = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_CHECK = 3'd2,
    ST_ACC   = 3'd3,
    ST_DEC   = 3'd4,
    ST_DONE  = 3'd5
  } mul_state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: Moore sequencer computing rtotal = rrow * rcol by repeated
// addition on the shared ALU, using rcoltemp as the down-counter.
// While busy it owns the ALU operand selects and the rtotal/rcoltemp strobes.
//
// Ports:
//   clk, rst     : clock (rising edge), synchronous active-high reset
//   start        : request a multiply, honoured only in IDLE
//   alu_z        : ALU zero flag of the current-cycle result
//   alu_cout     : ALU carry-out of the current-cycle result
//   busy, done   : busy in every non-IDLE state, done pulses in DONE
//   alu_a_sel/alu_b_sel/alu_op : ALU operand selects and operation
//   ld_rtotal, clr_rtotal, ld_rcoltemp : register strobes
//   ovf          : sticky overflow flag
//
// Optional feature macro: ALU_MUL_SEQ_OVF_CHECK_EN
//   defined   -> a carry-out during ACC sets ovf (sticky until INIT or rst)
//   undefined -> ovf is tied low and alu_cout is ignored
module alu_mul_seq
  import alu_defs_pkg::*;
#(
  parameter int SEL_W = 4,
  parameter int OP_W  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             alu_z,
  input  logic             alu_cout,
  output logic             busy,
  output logic             done,
  output logic [SEL_W-1:0] alu_a_sel,
  output logic [SEL_W-1:0] alu_b_sel,
  output logic [OP_W-1:0]  alu_op,
  output logic             ld_rtotal,
  output logic             clr_rtotal,
  output logic             ld_rcoltemp,
  output logic             ovf
);

  mul_state_t state_r;
  mul_state_t state_next_s;

  // Outputs are registered: decode the next state so the registered copy
  // always matches the state held in state_r (pure Moore timing).
  logic             busy_s;
  logic             done_s;
  logic [SEL_W-1:0] a_sel_s;
  logic [SEL_W-1:0] b_sel_s;
  logic [OP_W-1:0]  op_s;
  logic             ld_rtotal_s;
  logic             clr_rtotal_s;
  logic             ld_rcoltemp_s;

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_next_s = ST_INIT;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_INIT:  state_next_s = ST_CHECK;
      ST_CHECK: begin
        // rcoltemp is on the A bus with PASS, so alu_z means counter exhausted.
        if (alu_z) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_ACC;
        end
      end
      ST_ACC:   state_next_s = ST_DEC;
      ST_DEC:   state_next_s = ST_CHECK;
      ST_DONE:  state_next_s = ST_IDLE;
      default:  state_next_s = ST_IDLE;
    endcase
  end

  // Output decode of the state about to be entered.
  always_comb begin
    busy_s        = 1'b0;
    done_s        = 1'b0;
    a_sel_s       = SEL_NONE;
    b_sel_s       = SEL_NONE;
    op_s          = OP_PASS;
    ld_rtotal_s   = 1'b0;
    clr_rtotal_s  = 1'b0;
    ld_rcoltemp_s = 1'b0;
    case (state_next_s)
      ST_IDLE: begin
        busy_s = 1'b0;
      end
      ST_INIT: begin
        busy_s        = 1'b1;
        a_sel_s       = SEL_RCOL;
        ld_rcoltemp_s = 1'b1;
        clr_rtotal_s  = 1'b1;
      end
      ST_CHECK: begin
        busy_s  = 1'b1;
        a_sel_s = SEL_RCOLTEMP;
      end
      ST_ACC: begin
        busy_s      = 1'b1;
        a_sel_s     = SEL_RTOTAL;
        b_sel_s     = SEL_RROW;
        op_s        = OP_ADD;
        ld_rtotal_s = 1'b1;
      end
      ST_DEC: begin
        busy_s        = 1'b1;
        a_sel_s       = SEL_RCOLTEMP;
        op_s          = OP_DEC;
        ld_rcoltemp_s = 1'b1;
      end
      ST_DONE: begin
        busy_s = 1'b1;
        done_s = 1'b1;
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      alu_a_sel   <= SEL_NONE;
      alu_b_sel   <= SEL_NONE;
      alu_op      <= OP_PASS;
      ld_rtotal   <= 1'b0;
      clr_rtotal  <= 1'b0;
      ld_rcoltemp <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      busy        <= busy_s;
      done        <= done_s;
      alu_a_sel   <= a_sel_s;
      alu_b_sel   <= b_sel_s;
      alu_op      <= op_s;
      ld_rtotal   <= ld_rtotal_s;
      clr_rtotal  <= clr_rtotal_s;
      ld_rcoltemp <= ld_rcoltemp_s;
    end
  end

`ifdef ALU_MUL_SEQ_OVF_CHECK_EN
  // Sticky overflow: cleared on entry to INIT, set by a carry during ACC.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (state_next_s == ST_INIT) begin
      ovf <= 1'b0;
    end else if ((state_r == ST_ACC) && alu_cout) begin
      ovf <= 1'b1;
    end else begin
      ovf <= ovf;
    end
  end
`else
  logic unused_cout;
  assign unused_cout = alu_cout;
  assign ovf         = 1'b0;
`endif

endmodule

// File: tb/tb_alu_mul_seq.sv
// tb_alu_mul_seq: bench for alu_mul_seq. Models the 18-bit datapath
// (operand muxes, ALU, rtotal/rcoltemp registers) around the sequencer,
// checks the control decode every cycle from the cycle index, and checks
// product, done cycle and ovf through a scoreboard queue.
module tb_alu_mul_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic        alu_z;
  logic        alu_cout;
  logic        busy;
  logic        done;
  logic [3:0]  alu_a_sel;
  logic [3:0]  alu_b_sel;
  logic [2:0]  alu_op;
  logic        ld_rtotal;
  logic        clr_rtotal;
  logic        ld_rcoltemp;
  logic        ovf;

  logic [17:0] rrow, rcol, rtotal, rcoltemp;
  logic [17:0] a_val, b_val, res;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    logic [17:0] rrow;
    logic [17:0] rcol;
    logic [17:0] prod;
    logic        ovf_en;
    int          x1;
    int          x2;
  } vec_t;

  typedef struct {
    logic [17:0] prod;
    int          cyc;
    logic        ovf;
  } sb_t;

  vec_t vecs[9];
  sb_t  sbq[$];

  alu_mul_seq #(.SEL_W(4), .OP_W(3)) dut (
    .clk(clk), .rst(rst), .start(start), .alu_z(alu_z), .alu_cout(alu_cout),
    .busy(busy), .done(done), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
    .alu_op(alu_op), .ld_rtotal(ld_rtotal), .clr_rtotal(clr_rtotal),
    .ld_rcoltemp(ld_rcoltemp), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [17:0] mux(input logic [3:0] sel);
    case (sel)
      4'b0011: return rcol;
      4'b0100: return rrow;
      4'b0111: return rtotal;
      4'b1010: return rcoltemp;
      default: return 18'd0;
    endcase
  endfunction

  // Datapath model: muxes and ALU.
  always_comb begin
    a_val    = mux(alu_a_sel);
    b_val    = mux(alu_b_sel);
    res      = 18'd0;
    alu_cout = 1'b0;
    case (alu_op)
      3'b000:  res = a_val;
      3'b001:  {alu_cout, res} = {1'b0, a_val} + {1'b0, b_val};
      3'b010:  res = a_val - 18'd1;
      default: res = 18'd0;
    endcase
    alu_z = (res == 18'd0);
  end

  // Datapath registers.
  always @(posedge clk) begin
    if (clr_rtotal) rtotal <= 18'd0;
    else if (ld_rtotal) rtotal <= res;
    if (ld_rcoltemp) rcoltemp <= res;
  end

  // Expected {busy,done,a,b,op,ld_rtotal,clr_rtotal,ld_rcoltemp} in cycle c
  // of an operation with rcol = n (INIT is cycle 1).
  function automatic logic [15:0] exp_ctrl(input int c, input int n);
    int k;
    if (c < 1 || c > 3*n + 3) return 16'h0000;
    if (c == 1)         return {1'b1, 1'b0, 4'b0011, 4'b0000, 3'b000, 3'b011};
    if (c == 3*n + 3)   return {1'b1, 1'b1, 4'b0000, 4'b0000, 3'b000, 3'b000};
    k = (c - 2) % 3;
    if (k == 0)         return {1'b1, 1'b0, 4'b1010, 4'b0000, 3'b000, 3'b000};
    if (k == 1)         return {1'b1, 1'b0, 4'b0111, 4'b0100, 3'b001, 3'b100};
    return                     {1'b1, 1'b0, 4'b1010, 4'b0000, 3'b010, 3'b001};
  endfunction

  function automatic logic [15:0] act_ctrl();
    return {busy, done, alu_a_sel, alu_b_sel, alu_op, ld_rtotal, clr_rtotal, ld_rcoltemp};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Run one multiply; extra start pulses are driven in cycles x1/x2.
  task automatic run_vec(input vec_t v);
    int  n;
    int  n_acc;
    int  n_clr;
    int  n_done;
    sb_t e;
    sb_t got;
    n      = int'(v.rcol);
    n_acc  = 0;
    n_clr  = 0;
    n_done = 0;
    @(negedge clk);
    rrow  = v.rrow;
    rcol  = v.rcol;
    start = 1'b1;
    e.prod = v.prod;
    e.cyc  = 3*n + 3;
`ifdef ALU_MUL_SEQ_OVF_CHECK_EN
    e.ovf  = v.ovf_en;
`else
    e.ovf  = 1'b0;
`endif
    sbq.push_back(e);
    for (int c = 1; c <= 3*n + 5; c++) begin
      @(negedge clk);
      chk($sformatf("ctrl r%0d c%0d cyc%0d", v.rrow, v.rcol, c), 32'(act_ctrl()), 32'(exp_ctrl(c, n)));
      if (ld_rtotal) n_acc++;
      if (clr_rtotal) n_clr++;
      if (done) begin
        n_done++;
        if (sbq.size() == 0) begin
          chk("sb_empty_on_done", 32'd1, 32'd0);
        end else begin
          got = sbq.pop_front();
          chk($sformatf("rtotal r%0d c%0d", v.rrow, v.rcol), 32'(rtotal), 32'(got.prod));
          chk($sformatf("done_cycle r%0d c%0d", v.rrow, v.rcol), 32'(c), 32'(got.cyc));
          chk($sformatf("ovf r%0d c%0d", v.rrow, v.rcol), 32'(ovf), 32'(got.ovf));
        end
      end
      start = (c == v.x1 || c == v.x2) ? 1'b1 : 1'b0;
    end
    start = 1'b0;
    chk("acc_strobes", 32'(n_acc), 32'(n));
    chk("clr_strobes", 32'(n_clr), 32'd1);
    chk("done_pulses", 32'(n_done), 32'd1);
    if (n_done == 0 && sbq.size() != 0) begin
      got = sbq.pop_front();
      $display("FAIL timeout: done never seen for product %h", got.prod);
    end
  endtask

  initial begin
    vec_t rv;
    vecs[0] = '{18'd5,      18'd3, 18'd15,      1'b0, 0,  0};
    vecs[1] = '{18'd9,      18'd0, 18'd0,       1'b0, 0,  0};
    vecs[2] = '{18'd7,      18'd2, 18'd14,      1'b0, 2,  5};
    vecs[3] = '{18'd1000,   18'd4, 18'd4000,    1'b0, 15, 0};
    vecs[4] = '{18'h3FFFF,  18'd2, 18'h3FFFE,   1'b1, 0,  0};
    vecs[5] = '{18'h20000,  18'd2, 18'd0,       1'b1, 0,  0};
    vecs[6] = '{18'd1,      18'd1, 18'd1,       1'b0, 0,  0};
    vecs[7] = '{18'd0,      18'd5, 18'd0,       1'b0, 0,  0};
    vecs[8] = '{18'd12345,  18'd7, 18'd86415,   1'b0, 0,  0};

    rst   = 1'b1;
    start = 1'b0;
    rrow  = 18'd0;
    rcol  = 18'd0;
    repeat (2) @(negedge clk);
    chk("reset_ctrl", 32'(act_ctrl()), 32'd0);
    chk("reset_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run_vec(vecs[i]);
    end

    // Reset in the middle of a long multiply, then a normal run.
    @(negedge clk);
    rrow  = 18'd3;
    rcol  = 18'd10;
    start = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      start = 1'b0;
      chk($sformatf("rst_run cyc%0d", c), 32'(act_ctrl()), 32'(exp_ctrl(c, 10)));
    end
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_ctrl", 32'(act_ctrl()), 32'd0);
    chk("rst_mid_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("after_rst_idle", 32'(act_ctrl()), 32'd0);
    rv = '{18'd3, 18'd2, 18'd6, 1'b0, 0, 0};
    run_vec(rv);

    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/alu_mul_seq.md
Name: alu_mul_seq

Overview:
Multi-cycle controller that sequences the shared ALU, its A/B operand muxes and the register load enables to compute rtotal = rrow * rcol by repeated addition. rcoltemp is used as the down-counter.
- Sits beside the main control unit.
- While busy, it owns the ALU operand selects and the rtotal/rcoltemp load strobes.
- The control unit muxes its own selects with ours using busy.

Parameters:
SEL_W, 4, width of ALU operand-mux select codes
OP_W, 3, width of ALU operation code

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle request to begin a multiply; sampled only in IDLE
alu_z  in  1  ALU zero flag, combinational from the current-cycle ALU result
alu_cout  in  1  ALU carry-out of the current-cycle result (used only with OVF_CHECK_EN)
busy  out  1  high in every non-IDLE state
done  out  1  one-cycle pulse in DONE
alu_a_sel  out  SEL_W  ALU A-mux select
alu_b_sel  out  SEL_W  ALU B-mux select
alu_op  out  OP_W  ALU operation
ld_rtotal  out  1  rtotal load enable
clr_rtotal  out  1  rtotal synchronous clear
ld_rcoltemp  out  1  rcoltemp load enable
ovf  out  1  sticky overflow flag

Behaviour:
- Clock and reset: one clock domain, clk. Reset rst is synchronous and active-high.
- Output timing: Moore machine; all outputs decode from the state register only. No output depends combinationally on inputs.
- Idle/reset output values:
  - sels = 4'b0000 (mux yields 18'b0)
  - alu_op = OP_PASS
  - all enables 0, busy 0, done 0, ovf 0
- Select codes (shared package): SEL_NONE 0000, SEL_RCOL 0011, SEL_RROW 0100, SEL_RTOTAL 0111, SEL_RCOLTEMP 1010.
- Op codes: OP_PASS 000, OP_ADD 001, OP_DEC 010.
- States and per-state outputs:
  - IDLE: idle values. start=1 -> INIT.
  - INIT: a=RCOL, op=PASS, ld_rcoltemp=1, clr_rtotal=1, ovf cleared. -> CHECK.
  - CHECK: a=RCOLTEMP, op=PASS, no loads. alu_z=1 -> DONE, else -> ACC.
  - ACC: a=RTOTAL, b=RROW, op=ADD, ld_rtotal=1. -> DEC.
  - DEC: a=RCOLTEMP, op=DEC, ld_rcoltemp=1. -> CHECK.
  - DONE: done=1, idle selects. -> IDLE. rtotal is valid from this cycle on.
- Latency: from the start-sampled edge to done high is 3n+2 cycles, where n = rcol. done therefore asserts on cycle 3n+3 counting the INIT cycle as 1.
- Arithmetic: 18-bit modular; product = (rrow*rcol) mod 2^18.
- rcol=0: CHECK sees z immediately; rtotal = 0.
- start while busy: ignored. No queueing.
- start in DONE: ignored. Next start is accepted only from IDLE.
- rst mid-operation: next edge -> IDLE with idle outputs. rtotal/rcoltemp contents are left undefined-but-stale; the sequencer does not clear them.
- rrow/rcol changed by others while busy: illegal. The control unit must not load them while busy.

Optional Feature:
Macro ALU_MUL_SEQ_OVF_CHECK_EN.
- Defined: in ACC, alu_cout=1 sets ovf. ovf is sticky until the next INIT or rst, and is readable alongside done.
- Undefined: ovf is tied to 0 and alu_cout is unused. FSM and timing are identical.

Decomposition:
- Shared package alu_defs_pkg holds:
  - SEL_* codes, reused by the existing A-mux and the B-mux
  - OP_* codes
  - data width 18
  - state enum for this FSM
- No sub-module needed. The state register and output decode fit in a single module.

Test Plan:
- rcol=3, rrow=5, pulse start -> done at cycle 12, rtotal=15, ovf=0; ACC strobed exactly 3 times.
- rcol=0, rrow=9 -> done at cycle 3, rtotal=0, ld_rtotal never asserted, clr_rtotal once.
- rcol=2, start pulsed again at cycles 2 and 5 -> ignored; single done at cycle 9, rtotal=2*rrow.
- rcol=10, rst asserted at cycle 6 -> IDLE on next edge; busy=0, all sels 0000; a subsequent start runs normally to completion.
- OVF_CHECK_EN defined, rrow=2^17, rcol=2 -> rtotal=0, ovf=1 at done. Then rrow=1, rcol=1 -> ovf=0.
- Output decode check: in each state, compare alu_a_sel/alu_b_sel/alu_op/enables to the table above every cycle.
